// File: rtl/asconp_round_ctrl_if.sv
// Handshake, state and datapath bundle for the Ascon-p round controller.
// The abort_i wire exists only when ASCONP_ROUND_CTRL_ABORT_EN is defined.
interface asconp_round_ctrl_if;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  rounds_i;
   logic [63:0] s0_i, s1_i, s2_i, s3_i, s4_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] s0_o, s1_o, s2_o, s3_o, s4_o;
   logic [3:0]  round_cnt_o;
   logic [63:0] dp_x0_o, dp_x1_o, dp_x2_o, dp_x3_o, dp_x4_o;
   logic [63:0] dp_x0_i, dp_x1_i, dp_x2_i, dp_x3_i, dp_x4_i;
   logic        busy_o;
`ifdef ASCONP_ROUND_CTRL_ABORT_EN
   logic        abort_i;
`endif

   // Controller side
   modport slave (
      input  in_valid_i, rounds_i, s0_i, s1_i, s2_i, s3_i, s4_i,
      input  out_ready_i, dp_x0_i, dp_x1_i, dp_x2_i, dp_x3_i, dp_x4_i,
      output in_ready_o, out_valid_o, s0_o, s1_o, s2_o, s3_o, s4_o,
      output round_cnt_o, dp_x0_o, dp_x1_o, dp_x2_o, dp_x3_o, dp_x4_o,
      output busy_o
`ifdef ASCONP_ROUND_CTRL_ABORT_EN
      , input abort_i
`endif
   );

   // Requester / datapath side
   modport master (
      output in_valid_i, rounds_i, s0_i, s1_i, s2_i, s3_i, s4_i,
      output out_ready_i, dp_x0_i, dp_x1_i, dp_x2_i, dp_x3_i, dp_x4_i,
      input  in_ready_o, out_valid_o, s0_o, s1_o, s2_o, s3_o, s4_o,
      input  round_cnt_o, dp_x0_o, dp_x1_o, dp_x2_o, dp_x3_o, dp_x4_o,
      input  busy_o
`ifdef ASCONP_ROUND_CTRL_ABORT_EN
      , output abort_i
`endif
   );
endinterface

// File: rtl/asconp_round_ctrl.sv
// Ascon-p round controller: loads a 320-bit state, iterates an external
// one-round combinational datapath for 1..12 rounds, then holds the result
// under valid/ready. Optional abort port enabled by ASCONP_ROUND_CTRL_ABORT_EN.
module asconp_round_ctrl (
   input  logic clk_i,
   input  logic rst_i,
   asconp_round_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d, start_idx;
   logic [4:0][63:0] st_q, st_d, s_in, dp_in;
   logic             abort;
   logic             out_valid;

   assign s_in  = {bus.s4_i, bus.s3_i, bus.s2_i, bus.s1_i, bus.s0_i};
   assign dp_in = {bus.dp_x4_i, bus.dp_x3_i, bus.dp_x2_i, bus.dp_x1_i, bus.dp_x0_i};

`ifdef ASCONP_ROUND_CTRL_ABORT_EN
   assign abort = bus.abort_i;
`else
   assign abort = 1'b0;
`endif

   // Out-of-range round counts run the full 12 rounds (start index 0).
   assign start_idx = (bus.rounds_i == 4'd0 || bus.rounds_i > 4'd12) ?
                      4'd0 : 4'd12 - bus.rounds_i;

   // State, round index and state words; reset clears everything at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         st_q    <= st_d;
      end
   end

   // Next-state: accept in IDLE, one round per cycle in RUN, hold in DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      st_d    = st_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid_i) begin
               st_d    = s_in;
               idx_d   = start_idx;
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               st_d    = '0;
               idx_d   = 4'd0;
               state_d = IDLE;
            end else begin
               st_d = dp_in;
               if (idx_q == 4'd11) state_d = DONE;
               else                idx_d   = idx_q + 4'd1;
            end
         end
         DONE: begin
            if (abort) begin
               st_d    = '0;
               idx_d   = 4'd0;
               state_d = IDLE;
            end else if (bus.out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid       = (state_q == DONE);
   assign bus.out_valid_o = out_valid;
   assign bus.in_ready_o  = (state_q == IDLE) && !rst_i;
   assign bus.busy_o      = (state_q == RUN);
   assign bus.round_cnt_o = idx_q;

   assign bus.dp_x0_o = st_q[0];
   assign bus.dp_x1_o = st_q[1];
   assign bus.dp_x2_o = st_q[2];
   assign bus.dp_x3_o = st_q[3];
   assign bus.dp_x4_o = st_q[4];

   // Result words are gated so they read zero whenever no result is offered.
   assign bus.s0_o = out_valid ? st_q[0] : 64'd0;
   assign bus.s1_o = out_valid ? st_q[1] : 64'd0;
   assign bus.s2_o = out_valid ? st_q[2] : 64'd0;
   assign bus.s3_o = out_valid ? st_q[3] : 64'd0;
   assign bus.s4_o = out_valid ? st_q[4] : 64'd0;
endmodule

// File: tb/tb_asconp_round_ctrl.sv
// Self-checking bench for asconp_round_ctrl: supplies the Ascon round
// datapath, predicts every output per cycle from a transaction timeline, and
// pins latency / start index with literal expectations.
module tb_asconp_round_ctrl;
   typedef logic [4:0][63:0] st_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   asconp_round_ctrl_if bus();
   asconp_round_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] v, input int s);
      return (v >> s) | (v << (64 - s));
   endfunction

   // One Ascon permutation round with round constant for index r.
   function automatic st_t ascon_round(input st_t x, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [3:0]  hi;
      st_t         y;
      hi = 4'hf - r;
      x0 = x[0]; x1 = x[1]; x2 = x[2]; x3 = x[3]; x4 = x[4];
      x2 = x2 ^ {56'h0, hi, r};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      y[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      y[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      y[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      y[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      y[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return y;
   endfunction

   function automatic st_t rand_st();
      st_t s;
      for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
      return s;
   endfunction

   function automatic int eff_rounds(input int r);
      return (r == 0 || r > 12) ? 12 : r;
   endfunction

   // Combinational round datapath driven from the controller's state outputs.
   st_t dpo_w, so_w, dpi_w;
   assign dpo_w = {bus.dp_x4_o, bus.dp_x3_o, bus.dp_x2_o, bus.dp_x1_o, bus.dp_x0_o};
   assign so_w  = {bus.s4_o, bus.s3_o, bus.s2_o, bus.s1_o, bus.s0_o};
   assign dpi_w = ascon_round(dpo_w, bus.round_cnt_o);
   assign bus.dp_x0_i = dpi_w[0];
   assign bus.dp_x1_i = dpi_w[1];
   assign bus.dp_x2_i = dpi_w[2];
   assign bus.dp_x3_i = dpi_w[3];
   assign bus.dp_x4_i = dpi_w[4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_st(input string nm, input st_t act, input st_t exp);
      for (int k = 0; k < 5; k++) chk($sformatf("%s[%0d]", nm, k), act[k], exp[k]);
   endtask

   // Model: one outstanding transaction described by its accept cycle,
   // effective round count and the state after each round.
   int  n = 0;
   bit  act = 1'b0;
   bit  zeroed = 1'b1;
   int  acc_n = 0;
   int  eff_r = 12;
   st_t hist [0:12];
   int  acc_cnt = 0;
   // Observations of the DUT used by the literal latency/index checks.
   int  done_cnt = 0;
   int  obs_acc = -100;
   int  last_lat = 0;
   int  last_first = 0;
   bit  prev_ov = 1'b0;

   // Per-cycle compare on the falling edge, then advance the model.
   always @(negedge clk) begin
      int  p;
      st_t s;
      n++;
      if (rst) begin
         chk("rst_in_ready", bus.in_ready_o, 0);
         chk("rst_out_valid", bus.out_valid_o, 0);
         chk("rst_busy", bus.busy_o, 0);
         chk("rst_round_cnt", bus.round_cnt_o, 0);
         chk_st("rst_dp", dpo_w, '0);
         chk_st("rst_s_o", so_w, '0);
         act = 1'b0; zeroed = 1'b1; prev_ov = 1'b0;
      end else begin
         if (!act) begin
            chk("idle_in_ready", bus.in_ready_o, 1);
            chk("idle_out_valid", bus.out_valid_o, 0);
            chk("idle_busy", bus.busy_o, 0);
            chk_st("idle_s_o", so_w, '0);
            if (zeroed) begin
               chk("zero_round_cnt", bus.round_cnt_o, 0);
               chk_st("zero_dp", dpo_w, '0);
            end
         end else begin
            p = n - acc_n;
            if (p <= eff_r) begin
               chk("run_in_ready", bus.in_ready_o, 0);
               chk("run_out_valid", bus.out_valid_o, 0);
               chk("run_busy", bus.busy_o, 1);
               chk("run_round_cnt", bus.round_cnt_o, 64'(12 - eff_r + p - 1));
               chk_st("run_dp", dpo_w, hist[p-1]);
               chk_st("run_s_o", so_w, '0);
            end else begin
               chk("done_in_ready", bus.in_ready_o, 0);
               chk("done_out_valid", bus.out_valid_o, 1);
               chk("done_busy", bus.busy_o, 0);
               chk("done_round_cnt", bus.round_cnt_o, 11);
               chk_st("done_s_o", so_w, hist[eff_r]);
               chk_st("done_dp", dpo_w, hist[eff_r]);
            end
         end

         if (bus.in_ready_o && bus.in_valid_i) obs_acc = n;
         if (n == obs_acc + 1) last_first = int'(bus.round_cnt_o);
         if (bus.out_valid_o && !prev_ov) begin
            last_lat = n - obs_acc;
            done_cnt++;
         end
         prev_ov = bus.out_valid_o;

         if (act) begin
            p = n - acc_n;
`ifdef ASCONP_ROUND_CTRL_ABORT_EN
            if (bus.abort_i) begin
               act = 1'b0; zeroed = 1'b1;
            end else
`endif
            if (p > eff_r && bus.out_ready_i) act = 1'b0;
         end else if (bus.in_valid_i) begin
            act = 1'b1; zeroed = 1'b0; acc_n = n; acc_cnt++;
            eff_r = eff_rounds(int'(bus.rounds_i));
            s = {bus.s4_i, bus.s3_i, bus.s2_i, bus.s1_i, bus.s0_i};
            hist[0] = s;
            for (int k = 1; k <= eff_r; k++)
               hist[k] = ascon_round(hist[k-1], 4'(12 - eff_r + k - 1));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] r, input st_t s);
      int a;
      bit ok;
      st_t junk;
      a = acc_cnt; ok = 1'b0;
      bus.rounds_i = r;
      bus.s0_i = s[0]; bus.s1_i = s[1]; bus.s2_i = s[2]; bus.s3_i = s[3]; bus.s4_i = s[4];
      bus.in_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (acc_cnt != a) begin ok = 1'b1; break; end
      end
      bus.in_valid_i = 1'b0;
      junk = rand_st();
      bus.rounds_i = 4'($urandom);
      bus.s0_i = junk[0]; bus.s1_i = junk[1]; bus.s2_i = junk[2]; bus.s3_i = junk[3]; bus.s4_i = junk[4];
      chk("send_accept", ok, 1);
   endtask

   task automatic wait_done();
      int b;
      bit ok;
      b = done_cnt; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done_cnt != b) begin ok = 1'b1; break; end
      end
      chk("done_seen", ok, 1);
   endtask

   task automatic directed(input logic [3:0] r, input st_t s, input int exp_idx, input int exp_lat);
      send(r, s);
      wait_done();
      chk($sformatf("first_idx_r%0d", r), last_first, exp_idx);
      chk($sformatf("latency_r%0d", r), last_lat, exp_lat);
   endtask

   initial begin
      bit hit;
      int b;
      bus.in_valid_i  = 1'b0;
      bus.rounds_i    = 4'd0;
      bus.s0_i = '0; bus.s1_i = '0; bus.s2_i = '0; bus.s3_i = '0; bus.s4_i = '0;
      bus.out_ready_i = 1'b1;
`ifdef ASCONP_ROUND_CTRL_ABORT_EN
      bus.abort_i = 1'b0;
`endif
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      directed(4'd12, '0, 0, 13);
      directed(4'd6, rand_st(), 6, 7);
      directed(4'd8, rand_st(), 4, 9);
      directed(4'd0, rand_st(), 0, 13);
      directed(4'd15, rand_st(), 0, 13);

      // Backpressure: result must hold for 20 cycles.
      bus.out_ready_i = 1'b0;
      send(4'd12, rand_st());
      wait_done();
      repeat (20) tick();
      chk("bp_in_ready", bus.in_ready_o, 0);
      chk("bp_out_valid", bus.out_valid_o, 1);
      bus.out_ready_i = 1'b1;
      tick();
      chk("bp_release_in_ready", bus.in_ready_o, 1);

      // Reset mid-run at index 5.
      send(4'd12, rand_st());
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.busy_o && bus.round_cnt_o == 4'd5) begin hit = 1'b1; break; end
         tick();
      end
      chk("reach_idx5", hit, 1);
      rst = 1'b1;
      #1;
      chk("midrst_round_cnt", bus.round_cnt_o, 0);
      chk("midrst_busy", bus.busy_o, 0);
      chk("midrst_out_valid", bus.out_valid_o, 0);
      chk("midrst_in_ready", bus.in_ready_o, 0);
      chk_st("midrst_dp", dpo_w, '0);
      chk_st("midrst_s_o", so_w, '0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      directed(4'd12, rand_st(), 0, 13);

`ifdef ASCONP_ROUND_CTRL_ABORT_EN
      // Abort on the last round: no result pulse.
      send(4'd12, rand_st());
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.busy_o && bus.round_cnt_o == 4'd11) begin hit = 1'b1; break; end
         tick();
      end
      chk("reach_idx11", hit, 1);
      b = done_cnt;
      bus.abort_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
      chk("abort_in_ready", bus.in_ready_o, 1);
      chk("abort_out_valid", bus.out_valid_o, 0);
      tick();
      chk("abort_no_pulse", done_cnt - b, 0);
      // Abort while a result waits.
      bus.out_ready_i = 1'b0;
      send(4'd6, rand_st());
      wait_done();
      bus.abort_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
      bus.out_ready_i = 1'b1;
      chk("abort_done_in_ready", bus.in_ready_o, 1);
      chk("abort_done_out_valid", bus.out_valid_o, 0);
      // Abort in IDLE is ignored and the request still goes through.
      bus.abort_i = 1'b1;
      send(4'd8, rand_st());
      bus.abort_i = 1'b0;
      wait_done();
      chk("abort_idle_latency", last_lat, 9);
`endif

      // Randomized traffic with random result backpressure and gaps.
      for (int t = 0; t < 40; t++) begin
         int r;
         r = $urandom_range(0, 15);
         bus.out_ready_i = 1'($urandom_range(0, 1));
         send(4'(r), rand_st());
         wait_done();
         chk("rnd_latency", last_lat, eff_rounds(r) + 1);
         chk("rnd_first_idx", last_first, 12 - eff_rounds(r));
         repeat ($urandom_range(0, 3)) tick();
         bus.out_ready_i = 1'b1;
         tick();
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
